// File: rtl/l2norm_pkg.sv
// Shared types and helpers for the streaming L2-norm engine.
package l2norm_pkg;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        SQRT   = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    // Upper bound on any accumulator/beat-sum width handled by sat_add.
    localparam int MAX_W = 128;

    function automatic int beat_sum_w(input int lanes, input int elem_w);
        return 2 * elem_w + $clog2(lanes);
    endfunction

    // Adds a and b and clamps the result to 2^w-1; ovf reports the clamp.
    function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b,
                                                 input int unsigned      w,
                                                 output logic            ovf);
        logic [MAX_W:0] sum;
        logic [MAX_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ((MAX_W+1)'(1) << w) - (MAX_W+1)'(1);
        ovf = (sum > lim);
        return ovf ? lim[MAX_W-1:0] : sum[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/isqrt_radix4.sv
// Restoring integer square root: consumes two radicand bits per cycle,
// ACC_W/2 cycles after start; done pulses for one cycle with root valid.
module isqrt_radix4 #(
    parameter int ACC_W = 48
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [ACC_W-1:0]   radicand,
    output logic               busy,
    output logic               done,
    output logic [ACC_W/2-1:0] root
);
    localparam int OUT_W = ACC_W / 2;
    localparam int REM_W = OUT_W + 1;
    localparam int WRK_W = OUT_W + 3;
    localparam int CNT_W = $clog2(OUT_W + 1);

    logic [ACC_W-1:0] rad_q, rad_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [OUT_W-1:0] root_q, root_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WRK_W-1:0] rem_shift;
    logic [WRK_W-1:0] trial;
    logic             take;

    // Remainder never exceeds 2*root, so REM_W bits hold it between steps.
    always_comb begin
        rem_shift = {rem_q, rad_q[ACC_W-1 -: 2]};
        trial     = WRK_W'({root_q, 2'b01});
        take      = (rem_shift >= trial);

        rad_d  = rad_q;
        rem_d  = rem_q;
        root_d = root_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;

        if (start) begin
            rad_d  = radicand;
            rem_d  = '0;
            root_d = '0;
            cnt_d  = CNT_W'(OUT_W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rad_d  = rad_q << 2;
            rem_d  = REM_W'(take ? (rem_shift - trial) : rem_shift);
            root_d = OUT_W'({root_q, take});
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rad_q  <= rad_d;
            rem_q  <= rem_d;
            root_q <= root_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign root = root_q;

endmodule

// File: rtl/l2_norm_axis_multi.sv
// AXI-Stream L2 norm: sums squared kept lanes over a packet (saturating),
// then emits floor(sqrt(sum)) as a single back-pressured result beat.
module l2_norm_axis_multi
    import l2norm_pkg::*;
#(
    parameter  int LANES  = 4,
    parameter  int ELEM_W = 16,
    parameter  int ACC_W  = 48,
    localparam int OUT_W  = ACC_W / 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [LANES*ELEM_W-1:0] in_tdata,
    input  logic [LANES-1:0]        in_tkeep,
    input  logic                    in_tvalid,
    output logic                    in_tready,
    input  logic                    in_tlast,
    output logic [OUT_W-1:0]        out_tdata,
    output logic                    out_tuser,
    output logic                    out_tvalid,
    input  logic                    out_tready,
    output logic                    out_tlast,
    output state_t                  dbg_state_o
);
    localparam int BS_W = beat_sum_w(LANES, ELEM_W);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;
    logic [OUT_W-1:0] out_tdata_q, out_tdata_d;
    logic             out_tuser_q, out_tuser_d;
    logic             out_tvalid_q, out_tvalid_d;

    logic [BS_W-1:0]  beat_sum;
    logic [ACC_W-1:0] acc_next;
    logic             sat_ovf;
    logic             sq_start;
    logic             sq_busy;
    logic             sq_done;
    logic [OUT_W-1:0] sq_root;

    function automatic logic [2*ELEM_W-1:0] square(input logic signed [ELEM_W-1:0] e);
        logic signed [2*ELEM_W-1:0] p;
        p = (2*ELEM_W)'(e) * (2*ELEM_W)'(e);
        return p;
    endfunction

    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            if (in_tkeep[i]) begin
                beat_sum = beat_sum + BS_W'(square(in_tdata[i*ELEM_W +: ELEM_W]));
            end
        end
    end

    always_comb begin
        sat_ovf  = 1'b0;
        acc_next = ACC_W'(sat_add(MAX_W'(acc_q), MAX_W'(beat_sum), ACC_W, sat_ovf));
    end

    // Handshakes: a beat transfers on a rising edge where valid && ready; a
    // source holds its payload stable while valid is high and ready is low.
    assign in_tready = (state_q == ACCUM) && !reset;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        sat_d        = sat_q;
        out_tdata_d  = out_tdata_q;
        out_tuser_d  = out_tuser_q;
        out_tvalid_d = out_tvalid_q;
        sq_start     = 1'b0;
        case (state_q)
            ACCUM: begin
                if (in_tvalid) begin
                    acc_d = acc_next;
                    sat_d = sat_q | sat_ovf;
                    if (in_tlast) begin
                        sq_start = 1'b1;
                        state_d  = SQRT;
                    end
                end
            end
            SQRT: begin
                if (sq_done && !sq_busy) begin
                    out_tdata_d  = sq_root;
                    out_tuser_d  = sat_q;
                    out_tvalid_d = 1'b1;
                    state_d      = OUTPUT;
                end
            end
            OUTPUT: begin
                if (out_tready) begin
                    out_tvalid_d = 1'b0;
                    acc_d        = '0;
                    sat_d        = 1'b0;
                    state_d      = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ACCUM;
            acc_q        <= '0;
            sat_q        <= 1'b0;
            out_tdata_q  <= '0;
            out_tuser_q  <= 1'b0;
            out_tvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            sat_q        <= sat_d;
            out_tdata_q  <= out_tdata_d;
            out_tuser_q  <= out_tuser_d;
            out_tvalid_q <= out_tvalid_d;
        end
    end

    // The radicand is the post-update accumulator so the tlast beat counts.
    isqrt_radix4 #(.ACC_W(ACC_W)) u_isqrt (
        .clock    (clock),
        .reset    (reset),
        .start    (sq_start),
        .radicand (acc_next),
        .busy     (sq_busy),
        .done     (sq_done),
        .root     (sq_root)
    );

    assign out_tdata   = out_tdata_q;
    assign out_tuser   = out_tuser_q;
    assign out_tvalid  = out_tvalid_q;
    assign out_tlast   = out_tvalid_q;
    assign dbg_state_o = state_q;

endmodule
